// File: rtl/fx2_frame_writer.sv
// FX2 slave-FIFO write engine: frame FIFO plus 16-bit word serialiser throttled by flagb.
// Optional short-packet commit (pktend after an idle timeout) is built when FX2_PKTEND_EN is defined.
module fx2_frame_writer #(
    parameter int SAMPLE_W  = 32,
    parameter int CHANNELS  = 2,
    parameter int DEPTH     = 8,
    parameter int PKT_WORDS = 256,
    parameter int TIMEOUT   = 64
) (
    input  logic                         ifclk,
    input  logic                         reset_all,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         flagb,
    output logic [15:0]                  fd,
    output logic                         slwr,
    output logic                         pktend,
    output logic                         ovf
);

    // state | meaning
    // IDLE  | frame FIFO empty, bus quiet
    // SEND  | at least one frame buffered, words k=0..FW-1 go out while flagb=1

    localparam int FW = CHANNELS * SAMPLE_W / 16;
    localparam int AW = $clog2(DEPTH);
    localparam int KW = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(FW - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [FW-1:0][15:0] frame_mem [DEPTH];
    logic [FW-1:0][15:0] head;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [KW-1:0]   k_q, k_d;
    logic [15:0]     fd_q, fd_d;
    logic            slwr_q, slwr_d;
    logic            pktend_q, pktend_d;
    logic            ovf_q, ovf_d;

    logic full;
    logic emit;
    logic pop;
    logic push;
    logic fire;

    assign full    = (count_q == FULL_CNT);
    assign s_ready = !full;
    assign head    = frame_mem[rd_ptr_q];

    assign fd     = fd_q;
    assign slwr   = slwr_q;
    assign pktend = pktend_q;
    assign ovf    = ovf_q;

`ifdef FX2_PKTEND_EN
    localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [PW-1:0] wc_q, wc_d;
    logic [TW-1:0] idle_q, idle_d;

    // idle_q is a down-counter reloaded on every write; terminal count with words pending commits.
    assign fire = (idle_q == '0) && (wc_q != '0);
`else
    // Commit logic not built; the packet parameters only keep the interface uniform.
    assign fire = (PKT_WORDS == 0) && (TIMEOUT == 0);
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        k_d      = k_q;
        fd_d     = fd_q;
        slwr_d   = 1'b1;
        pktend_d = !fire;
        ovf_d    = ovf_q;

        emit = (state_q == SEND) && flagb && !fire;
        pop  = emit && (k_q == K_LAST);
        // A full FIFO still takes a frame on the edge that frees a slot.
        push = s_valid && (!full || pop);

        if (emit) begin
            fd_d   = head[k_q];
            slwr_d = 1'b0;
            k_d    = pop ? '0 : k_q + KW'(1);
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (s_valid && !push) ovf_d = 1'b1;

        state_d = (count_d != '0) ? SEND : IDLE;
    end

`ifdef FX2_PKTEND_EN
    always_comb begin
        wc_d   = wc_q;
        idle_d = idle_q;
        if (emit) begin
            idle_d = TW'(TIMEOUT - 1);
            wc_d   = (wc_q == PW'(PKT_WORDS - 1)) ? '0 : wc_q + PW'(1);
        end else if (idle_q != '0) begin
            idle_d = idle_q - TW'(1);
        end
        if (fire) wc_d = '0;
    end
`endif

    always_ff @(posedge ifclk or posedge reset_all) begin
        if (reset_all) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            k_q      <= '0;
            fd_q     <= '0;
            slwr_q   <= 1'b1;
            pktend_q <= 1'b1;
            ovf_q    <= 1'b0;
`ifdef FX2_PKTEND_EN
            wc_q     <= '0;
            idle_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            k_q      <= k_d;
            fd_q     <= fd_d;
            slwr_q   <= slwr_d;
            pktend_q <= pktend_d;
            ovf_q    <= ovf_d;
`ifdef FX2_PKTEND_EN
            wc_q     <= wc_d;
            idle_q   <= idle_d;
`endif
        end
    end

    // Frame storage is plain RAM; validity is tracked by the pointers and count.
    always_ff @(posedge ifclk) begin
        if (push) frame_mem[wr_ptr_q] <= s_data;
    end

endmodule
